// File: rtl/fpa_pkg.sv
// Shared constants and types for the FP adder normalise/round/pack stage.
package fpa_pkg;

  typedef enum logic [1:0] {
    SP_NORM = 2'b00,
    SP_INF  = 2'b01,
    SP_NAN  = 2'b10,
    SP_RSV  = 2'b11
  } special_e;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  // Mantissa datapath bit positions: hidden bit, round lsb, guard
  localparam int HID_BIT = 30;
  localparam int LSB_BIT = 7;
  localparam int GRD_BIT = 6;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; returns 32 for an all-zero input.
module lzc32 (
  input  logic [31:0] value,
  output logic [5:0]  count
);

  // Ascending scan so the most significant set bit wins
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) count = 6'(31 - i);
    end
  end

endmodule

// File: rtl/fpa_add_norm.sv
// Two-stage add/subtract, normalise, round-to-nearest-even and IEEE-754 single pack
// for aligned mantissa pairs, with a valid/ready handshake on both sides.
module fpa_add_norm
  import fpa_pkg::*;
#(
  parameter int MW = 32,
  parameter int EW = 8,
  parameter int FW = 23
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MW-1:0]   mant_l,
  input  logic [MW-1:0]   mant_s,
  input  logic [EW-1:0]   exp_l,
  input  logic            sign_l,
  input  logic            eff_sub,
  input  logic [1:0]      special,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [EW+FW:0]  result,
  output logic            ovf,
  output logic            unf
);

  logic          s1_valid;
  logic [MW-1:0] s1_sum;
  logic [EW-1:0] s1_exp;
  logic          s1_sign;
  special_e      s1_special;

  logic          en1;
  logic          en2;

  logic [5:0]          lz;
  logic [30:0]         nm;
  logic signed [9:0]   exp_n;
  logic signed [9:0]   exp_f;
  logic                rnd_up;
  logic [24:0]         rnd;
  logic [FW-1:0]       frac;
  logic [EW+FW:0]      nxt_result;
  logic                nxt_ovf;
  logic                nxt_unf;

  assign en2      = ~out_valid | out_ready;
  assign en1      = ~s1_valid | en2;
  assign in_ready = en1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_sum     <= '0;
      s1_exp     <= '0;
      s1_sign    <= 1'b0;
      s1_special <= SP_NORM;
    end else if (en1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum     <= eff_sub ? (mant_l - mant_s) : (mant_l + mant_s);
        s1_exp     <= exp_l;
        s1_sign    <= sign_l;
        s1_special <= special_e'(special);
      end
    end
  end

  lzc32 u_lzc (
    .value (s1_sum),
    .count (lz)
  );

  // Normalise so the hidden bit lands on HID_BIT; a carry-out shift keeps bit0 as sticky
  always_comb begin
    if (s1_sum[31]) begin
      nm    = {s1_sum[31:2], |s1_sum[1:0]};
      exp_n = $signed({2'b00, s1_exp}) + 10'sd1;
    end else begin
      nm    = 31'(s1_sum << (lz - 6'd1));
      exp_n = $signed({2'b00, s1_exp}) - $signed({4'b0000, lz}) + 10'sd1;
    end

    rnd_up = nm[GRD_BIT] & ((|nm[GRD_BIT-1:0]) | nm[LSB_BIT]);
    rnd    = {1'b0, nm[HID_BIT:LSB_BIT]} + {24'd0, rnd_up};

    if (rnd[24]) begin
      frac  = rnd[FW:1];
      exp_f = exp_n + 10'sd1;
    end else begin
      frac  = rnd[FW-1:0];
      exp_f = exp_n;
    end

    nxt_ovf    = 1'b0;
    nxt_unf    = 1'b0;
    nxt_result = {s1_sign, exp_f[EW-1:0], frac};
    if (s1_special == SP_INF) begin
      nxt_result = {s1_sign, EXP_MAX, {FW{1'b0}}};
    end else if (s1_special != SP_NORM) begin
      nxt_result = QNAN;
    end else if (s1_sum == '0) begin
      nxt_result = '0;
    end else if (exp_f >= 10'sd255) begin
      nxt_result = {s1_sign, EXP_MAX, {FW{1'b0}}};
      nxt_ovf    = 1'b1;
    end else if (exp_f <= 10'sd0) begin
      nxt_result = {s1_sign, {(EW+FW){1'b0}}};
      nxt_unf    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else if (en2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= nxt_result;
        ovf    <= nxt_ovf;
        unf    <= nxt_unf;
      end
    end
  end

endmodule

// File: tb/tb_fpa_add_norm.sv
// Self-checking bench for fpa_add_norm: directed corner cases plus a randomized
// stream scored against an arithmetic reference model.
module tb_fpa_add_norm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] mant_l = '0;
  logic [31:0] mant_s = '0;
  logic [7:0]  exp_l = '0;
  logic        sign_l = 1'b0;
  logic        eff_sub = 1'b0;
  logic [1:0]  special = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        ovf;
  logic        unf;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] r;
    logic        o;
    logic        u;
  } exp_t;

  always #5 clk = ~clk;

  fpa_add_norm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_l    (mant_l),
    .mant_s    (mant_s),
    .exp_l     (exp_l),
    .sign_l    (sign_l),
    .eff_sub   (eff_sub),
    .special   (special),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .unf       (unf)
  );

  // Reference: exact sum, find its MSB, round the scaled integer to nearest even
  function automatic exp_t model(input logic [31:0] ml, input logic [31:0] ms, input logic [7:0] el,
                                 input logic sl, input logic es, input logic [1:0] sp);
    exp_t   x;
    longint s, q, rem, half;
    int     p, e, k;
    x = '0;
    if (sp == 2'b01) begin
      x.r = {sl, 8'hFF, 23'h0};
      return x;
    end
    if (sp[1]) begin
      x.r = 32'h7FC00000;
      return x;
    end
    s = es ? (longint'(ml) - longint'(ms)) : (longint'(ml) + longint'(ms));
    if (s == 0) return x;
    p = 0;
    for (int i = 0; i < 40; i++) if (s[i]) p = i;
    e = int'(el) + p - 30;
    k = p - 23;
    if (k <= 0) begin
      q = s << (-k);
    end else begin
      q    = s >> k;
      rem  = s & ((longint'(1) << k) - 1);
      half = longint'(1) << (k - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      x.r = {sl, 8'hFF, 23'h0};
      x.o = 1'b1;
    end else if (e <= 0) begin
      x.r = {sl, 31'h0};
      x.u = 1'b1;
    end else begin
      x.r = {sl, 8'(e), q[22:0]};
    end
    return x;
  endfunction

  task automatic gen_op(output logic [31:0] ml, output logic [31:0] ms, output logic [7:0] el,
                        output logic sl, output logic es, output logic [1:0] sp);
    logic [31:0] a, b, t;
    int sh;
    a  = 32'h40000000 | ($urandom & 32'h3FFFFFFF);
    b  = 32'h40000000 | ($urandom & 32'h3FFFFFFF);
    sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3));
    b  = b >> sh;
    if ($urandom_range(0, 15) == 0) b = a;
    if (b > a) begin
      t = a; a = b; b = t;
    end
    ml = a;
    ms = b;
    case ($urandom_range(0, 3))
      0:       el = 8'($urandom_range(1, 8));
      1:       el = 8'($urandom_range(247, 254));
      default: el = 8'($urandom_range(1, 254));
    endcase
    sl = 1'($urandom_range(0, 1));
    es = 1'($urandom_range(0, 1));
    sp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
  endtask

  task automatic drive(input logic [31:0] ml, input logic [31:0] ms, input logic [7:0] el,
                       input logic sl, input logic es, input logic [1:0] sp);
    mant_l  = ml;
    mant_s  = ms;
    exp_l   = el;
    sign_l  = sl;
    eff_sub = es;
    special = sp;
  endtask

  task automatic run_op(input logic [31:0] ml, input logic [31:0] ms, input logic [7:0] el,
                        input logic sl, input logic es, input logic [1:0] sp,
                        output logic [31:0] r, output logic o, output logic u, output int lat);
    int wait_cnt;
    @(negedge clk);
    drive(ml, ms, el, sl, es, sp);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 10) begin
      @(negedge clk);
      #1;
      wait_cnt++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    r = result;
    o = ovf;
    u = unf;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid actual=%b expected=0", out_valid); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result actual=%h expected=00000000", result); end
    checks++; if ({ovf, unf} !== 2'b00) begin failures++; $display("FAIL reset_flags actual=%b expected=00", {ovf, unf}); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready actual=%b expected=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] r; logic o, u; int lat;
    run_op(32'h40000000, 32'h40000000, 8'd127, 1'b0, 1'b0, 2'b00, r, o, u, lat);
    checks++; if (r !== 32'h40000000) begin failures++; $display("FAIL add_1p1 actual=%h expected=40000000", r); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL latency actual=%0d expected=2", lat); end
    run_op(32'h60000000, 32'h40000000, 8'd127, 1'b0, 1'b1, 2'b00, r, o, u, lat);
    checks++; if (r !== 32'h3F000000) begin failures++; $display("FAIL sub_1p5_1 actual=%h expected=3F000000", r); end
    run_op(32'h40000000, 32'h40000000, 8'd127, 1'b1, 1'b1, 2'b00, r, o, u, lat);
    checks++; if ({r, u} !== {32'h0, 1'b0}) begin failures++; $display("FAIL cancel actual=%h unf=%b expected=00000000 unf=0", r, u); end
    run_op(32'h40000000, 32'h0, 8'd1, 1'b0, 1'b0, 2'b00, r, o, u, lat);
    checks++; if ({r, u} !== {32'h00800000, 1'b0}) begin failures++; $display("FAIL min_normal actual=%h unf=%b expected=00800000 unf=0", r, u); end
  endtask

  task automatic test_rne();
    logic [31:0] r; logic o, u; int lat;
    run_op(32'h40000000, 32'h40, 8'd127, 1'b0, 1'b0, 2'b00, r, o, u, lat);
    checks++; if (r !== 32'h3F800000) begin failures++; $display("FAIL rne_tie_even actual=%h expected=3F800000", r); end
    run_op(32'h40000080, 32'h40, 8'd127, 1'b0, 1'b0, 2'b00, r, o, u, lat);
    checks++; if (r !== 32'h3F800002) begin failures++; $display("FAIL rne_tie_odd actual=%h expected=3F800002", r); end
    run_op(32'h7FFFFFC0, 32'h0, 8'd127, 1'b0, 1'b0, 2'b00, r, o, u, lat);
    checks++; if (r !== 32'h40000000) begin failures++; $display("FAIL rne_carry actual=%h expected=40000000", r); end
  endtask

  task automatic test_overflow_special();
    logic [31:0] r; logic o, u; int lat;
    run_op(32'h7FFFFF80, 32'h7FFFFF80, 8'd254, 1'b0, 1'b0, 2'b00, r, o, u, lat);
    checks++; if ({r, o} !== {32'h7F800000, 1'b1}) begin failures++; $display("FAIL overflow actual=%h ovf=%b expected=7F800000 ovf=1", r, o); end
    run_op(32'h40000000, 32'h0, 8'd254, 1'b0, 1'b0, 2'b00, r, o, u, lat);
    checks++; if ({r, o} !== {32'h7F000000, 1'b0}) begin failures++; $display("FAIL max_exp actual=%h ovf=%b expected=7F000000 ovf=0", r, o); end
    run_op(32'h7FFFFF80, 32'h7FFFFF80, 8'd254, 1'b0, 1'b0, 2'b10, r, o, u, lat);
    checks++; if ({r, o} !== {32'h7FC00000, 1'b0}) begin failures++; $display("FAIL nan actual=%h ovf=%b expected=7FC00000 ovf=0", r, o); end
    run_op(32'h40000000, 32'h40000000, 8'd100, 1'b1, 1'b0, 2'b01, r, o, u, lat);
    checks++; if ({r, o, u} !== {32'hFF800000, 2'b00}) begin failures++; $display("FAIL inf actual=%h flags=%b%b expected=FF800000 flags=00", r, o, u); end
    run_op(32'h40000000, 32'h40000000, 8'd100, 1'b0, 1'b1, 2'b11, r, o, u, lat);
    checks++; if (r !== 32'h7FC00000) begin failures++; $display("FAIL reserved actual=%h expected=7FC00000", r); end
  endtask

  task automatic test_underflow();
    logic [31:0] r; logic o, u; int lat;
    run_op(32'h40000000, 32'h3F000000, 8'd5, 1'b1, 1'b1, 2'b00, r, o, u, lat);
    checks++; if ({r, u} !== {32'h80000000, 1'b1}) begin failures++; $display("FAIL underflow actual=%h unf=%b expected=80000000 unf=1", r, u); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ml[6], ms[6]; logic [7:0] el[6]; logic sl[6], es[6]; logic [1:0] sp[6];
    exp_t ex[6];
    int got = 0;
    for (int i = 0; i < 6; i++) begin
      gen_op(ml[i], ms[i], el[i], sl[i], es[i], sp[i]);
      ex[i] = model(ml[i], ms[i], el[i], sl[i], es[i], sp[i]);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (c < 6);
      if (c < 6) drive(ml[c], ms[c], el[c], sl[c], es[c], sp[c]);
      #1;
      if (c < 6) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready cycle=%0d actual=%b expected=1", c, in_ready); end
      end
      checks++; if (out_valid !== (c >= 2 && c <= 7)) begin failures++; $display("FAIL b2b_out_valid cycle=%0d actual=%b expected=%b", c, out_valid, (c >= 2 && c <= 7)); end
      if (out_valid && got < 6) begin
        checks++; if ({result, ovf, unf} !== ex[got]) begin failures++; $display("FAIL b2b_result idx=%0d actual=%h/%b%b expected=%h/%b%b", got, result, ovf, unf, ex[got].r, ex[got].o, ex[got].u); end
        got++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] ml[4], ms[4]; logic [7:0] el[4]; logic sl[4], es[4]; logic [1:0] sp[4];
    exp_t ex[4];
    int idx, got, cyc;
    for (int i = 0; i < 4; i++) begin
      gen_op(ml[i], ms[i], el[i], sl[i], es[i], sp[i]);
      ex[i] = model(ml[i], ms[i], el[i], sl[i], es[i], sp[i]);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(ml[c], ms[c], el[c], sl[c], es[c], sp[c]);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept op=%0d in_ready actual=%b expected=1", c, in_ready); end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(ml[2], ms[2], el[2], sl[2], es[2], sp[2]);
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full in_ready stall=%0d actual=%b expected=0", c, in_ready); end
      checks++; if ({out_valid, result} !== {1'b1, ex[0].r}) begin failures++; $display("FAIL bp_hold stall=%0d actual=%b/%h expected=1/%h", c, out_valid, result, ex[0].r); end
    end
    idx = 2;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 15) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (idx < 4);
      if (idx < 4) drive(ml[idx], ms[idx], el[idx], sl[idx], es[idx], sp[idx]);
      #1;
      if (out_valid) begin
        checks++; if ({result, ovf, unf} !== ex[got]) begin failures++; $display("FAIL bp_order idx=%0d actual=%h/%b%b expected=%h/%b%b", got, result, ovf, unf, ex[got].r, ex[got].o, ex[got].u); end
        got++;
      end
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++; if ({got, out_valid} !== {32'd4, 1'b0}) begin failures++; $display("FAIL bp_count actual=%0d extra_valid=%b expected=4 extra_valid=0", got, out_valid); end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(32'h40000000, 32'h20000000, 8'd120, 1'b0, 1'b0, 2'b00);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_setup out_valid actual=%b expected=1", out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 32'h0}) begin failures++; $display("FAIL rst_mid_async actual=%b/%b/%h expected=0/1/00000000", out_valid, in_ready, result); end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) stray++;
    end
    checks++; if (stray !== 0) begin failures++; $display("FAIL rst_mid_dropped stray_outputs actual=%0d expected=0", stray); end
  endtask

  task automatic test_random();
    exp_t sb[$];
    exp_t e;
    logic [31:0] ml, ms; logic [7:0] el; logic sl, es; logic [1:0] sp;
    logic pend = 1'b0;
    int cyc;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!pend && $urandom_range(0, 4) != 0) begin
        gen_op(ml, ms, el, sl, es, sp);
        pend = 1'b1;
      end
      in_valid = pend;
      drive(ml, ms, el, sl, es, sp);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL rand_unexpected actual=%h expected=no_output", result);
        end else begin
          e = sb.pop_front();
          checks++; if ({result, ovf, unf} !== e) begin failures++; $display("FAIL rand_result actual=%h/%b%b expected=%h/%b%b", result, ovf, unf, e.r, e.o, e.u); end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(ml, ms, el, sl, es, sp));
        pend = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (sb.size() > 0 && cyc < 20) begin
      @(negedge clk);
      #1;
      if (out_valid) begin
        e = sb.pop_front();
        checks++; if ({result, ovf, unf} !== e) begin failures++; $display("FAIL rand_drain actual=%h/%b%b expected=%h/%b%b", result, ovf, unf, e.r, e.o, e.u); end
      end
      cyc++;
    end
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL rand_lost actual=%0d expected=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rne();
    test_overflow_special();
    test_underflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
